alu_cmd_driver: RTL and testbench

Initiator-side sequencer for the team's combinational multifunction ALU. It accepts operand/opcode commands over a valid/ready stream and drives X, Y and C into an external ALU instance. After a programmable settle time it samples the ALU result and returns it on a valid/ready response stream. It sits between the command source (testbench, host FSM or microsequencer) and the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_driver.sv | 127 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcode map and driver state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_HALF_SUM     = 3'b000;
  localparam logic [OP_W-1:0] OP_DBL_SUM      = 3'b001;
  localparam logic [OP_W-1:0] OP_X_PLUS_HALFY = 3'b010;
  localparam logic [OP_W-1:0] OP_HALF_DIFF    = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND         = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT_X        = 3'b101;
  localparam logic [OP_W-1:0] OP_NOR          = 3'b110;
  localparam logic [OP_W-1:0] OP_XOR          = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequencer that drives one command into an external combinational ALU and returns its result.
// Optional response counter output op_count enabled by ALU_CMD_DRIVER_OP_COUNT_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_x,
  input  logic [N-1:0]      cmd_y,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [N-1:0]      alu_x,
  output logic [N-1:0]      alu_y,
  output logic [OP_W-1:0]   alu_c,
  input  logic [N+1:0]      alu_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N+1:0]      rsp_data,
  output logic [OP_W-1:0]   rsp_op,
  output logic              busy
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  drv_state_t        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [N-1:0]      alu_x_nxt, alu_y_nxt;
  logic [OP_W-1:0]   alu_c_nxt, rsp_op_nxt;
  logic [N+1:0]      rsp_data_nxt;
  logic              rsp_valid_nxt;
  logic              busy_nxt;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
  logic [15:0]       op_count_nxt;
`endif

  // Ready is a pure decode of state so a command can land on the first idle edge.
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_c     <= '0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
      op_count  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      alu_x     <= alu_x_nxt;
      alu_y     <= alu_y_nxt;
      alu_c     <= alu_c_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_op    <= rsp_op_nxt;
      rsp_valid <= rsp_valid_nxt;
      busy      <= busy_nxt;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
      op_count  <= op_count_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    alu_x_nxt     = alu_x;
    alu_y_nxt     = alu_y;
    alu_c_nxt     = alu_c;
    rsp_data_nxt  = rsp_data;
    rsp_op_nxt    = rsp_op;
    rsp_valid_nxt = rsp_valid;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
    op_count_nxt  = op_count;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          alu_x_nxt = cmd_x;
          alu_y_nxt = cmd_y;
          alu_c_nxt = cmd_op;
          cnt_nxt   = CW'(SETTLE_CYC);
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // Counter reaching 1 marks the edge SETTLE_CYC cycles after acceptance.
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rsp_data_nxt  = alu_o;
          rsp_op_nxt    = alu_c;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
          op_count_nxt  = op_count + 16'd1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench: SETTLE_CYC=1 and SETTLE_CYC=3 instances fed by a stub or reference ALU.
module tb_alu_cmd_driver;

  localparam int unsigned N  = 3;
  localparam int unsigned OW = N + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsp_ready = 1'b0;
  logic [N-1:0] cx = '0, cy = '0;
  logic [2:0]   cop = '0;
  logic [OW-1:0] stub_o = '0;
  logic use_real = 1'b0;

  logic cv1 = 1'b0, cv3 = 1'b0;
  logic cr1, cr3, rv1, rv3, busy1, busy3;
  logic [N-1:0] ax1, ay1, ax3, ay3;
  logic [2:0] ac1, ac3, rop1, rop3;
  logic [OW-1:0] ao1, ao3, rd1, rd3;
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
  logic [15:0] opc1, opc3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Reference for the bitwise opcodes; arithmetic opcodes are not exercised here.
  function automatic logic [OW-1:0] alu_ref(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic [2:0] c);
    logic [OW-1:0] xs, ys;
    xs = {{2{x[N-1]}}, x};
    ys = {{2{y[N-1]}}, y};
    case (c)
      3'b100:  return ~(xs & ys);
      3'b101:  return ~xs;
      3'b110:  return ~(xs | ys);
      3'b111:  return xs ^ ys;
      default: return '0;
    endcase
  endfunction

  assign ao1 = use_real ? alu_ref(ax1, ay1, ac1) : stub_o;
  assign ao3 = use_real ? alu_ref(ax3, ay3, ac3) : stub_o;

  alu_cmd_driver #(.N(N), .SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cr1),
    .cmd_x(cx), .cmd_y(cy), .cmd_op(cop),
    .alu_x(ax1), .alu_y(ay1), .alu_c(ac1), .alu_o(ao1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_op(rop1),
    .busy(busy1)
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
    , .op_count(opc1)
`endif
  );

  alu_cmd_driver #(.N(N), .SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv3), .cmd_ready(cr3),
    .cmd_x(cx), .cmd_y(cy), .cmd_op(cop),
    .alu_x(ax3), .alu_y(ay3), .alu_c(ac3), .alu_o(ao3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_data(rd3), .rsp_op(rop3),
    .busy(busy3)
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
    , .op_count(opc3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hs_cyc[$];
    int hs_cnt;

    // Reset values
    #2;
    check("rst_rsp_valid", 32'(rv1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_alu_x", 32'(ax1), 32'd0);
    check("rst_rsp_data", 32'(rd1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cr1), 32'd1);

    // SETTLE_CYC=1 with stub result
    cx = 3'b010; cy = 3'b001; cop = 3'b111; cv1 = 1'b1; stub_o = 5'b10110;
    tick();
    cv1 = 1'b0;
    check("t2_alu_x", 32'(ax1), 32'b010);
    check("t2_alu_y", 32'(ay1), 32'b001);
    check("t2_alu_c", 32'(ac1), 32'b111);
    check("t2_busy", 32'(busy1), 32'd1);
    check("t2_cmd_ready", 32'(cr1), 32'd0);
    check("t2_no_early_valid", 32'(rv1), 32'd0);
    tick();
    check("t2_rsp_valid", 32'(rv1), 32'd1);
    check("t2_rsp_data", 32'(rd1), 32'b10110);
    check("t2_rsp_op", 32'(rop1), 32'b111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t2_rsp_drop", 32'(rv1), 32'd0);
    check("t2_back_idle", 32'(cr1), 32'd1);
    check("t2_busy_clr", 32'(busy1), 32'd0);
    check("t2_alu_x_held", 32'(ax1), 32'b010);

    // Reference ALU: NOT X and XOR
    use_real = 1'b1;
    cx = 3'b010; cy = 3'b000; cop = 3'b101; cv1 = 1'b1;
    tick();
    cv1 = 1'b0;
    tick();
    check("t3_not_x", 32'(rd1), 32'b11101);
    check("t3_not_x_op", 32'(rop1), 32'b101);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cx = 3'b011; cy = 3'b101; cop = 3'b111; cv1 = 1'b1;
    tick();
    cv1 = 1'b0;
    tick();
    check("t3_xor", 32'(rd1), 32'b11110);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    use_real = 1'b0;

    // Backpressure: result frozen, next command waits for the handshake
    cx = 3'b001; cy = 3'b011; cop = 3'b100; cv1 = 1'b1; stub_o = 5'b01010;
    tick();
    cx = 3'b110; cy = 3'b111; cop = 3'b000;
    tick();
    check("t4_valid", 32'(rv1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      stub_o = 5'(i * 7 + 1);
      tick();
      check($sformatf("t4_hold_data_%0d", i), 32'(rd1), 32'b01010);
      check($sformatf("t4_no_accept_%0d", i), 32'(ac1), 32'b100);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4_hs_idle", 32'(cr1), 32'd1);
    check("t4_alu_c_after_hs", 32'(ac1), 32'b100);
    tick();
    cv1 = 1'b0;
    check("t4_next_accept_c", 32'(ac1), 32'b000);
    check("t4_next_accept_x", 32'(ax1), 32'b110);
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // SETTLE_CYC=3: the value present at k+2 is stale, k+3 is captured
    cx = 3'b001; cy = 3'b001; cop = 3'b110; cv3 = 1'b1; stub_o = 5'b00001;
    tick();
    cv3 = 1'b0;
    tick();
    check("t5_k1_no_valid", 32'(rv3), 32'd0);
    stub_o = 5'b00111;
    tick();
    check("t5_k2_no_valid", 32'(rv3), 32'd0);
    stub_o = 5'b11000;
    tick();
    check("t5_k3_valid", 32'(rv3), 32'd1);
    check("t5_k3_data", 32'(rd3), 32'b11000);
    check("t5_k3_op", 32'(rop3), 32'b110);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset mid-DRIVE drops the command
    cx = 3'b011; cy = 3'b010; cop = 3'b011; cv3 = 1'b1;
    tick();
    cv3 = 1'b0;
    check("t1_in_drive", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(rv3), 32'd0);
    check("t1_rst_busy", 32'(busy3), 32'd0);
    check("t1_rst_alu_c", 32'(ac3), 32'd0);
    check("t1_rst_rsp_data", 32'(rd3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t1_release_ready", 32'(cr3), 32'd1);
    check("t1_release_valid", 32'(rv3), 32'd0);

    // Back-to-back commands with rsp_ready held high
    cx = 3'b101; cy = 3'b010; cop = 3'b010; cv3 = 1'b1; rsp_ready = 1'b1; stub_o = 5'b00011;
    hs_cnt = 0;
    for (int cyc = 0; cyc < 100 && hs_cnt < 4; cyc++) begin
      tick();
      if (rv3 && rsp_ready) begin
        hs_cyc.push_back(cyc);
        hs_cnt++;
        if (hs_cnt == 4) cv3 = 1'b0;
      end
    end
    check("t6_responses", 32'(hs_cnt), 32'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      check($sformatf("t6_spacing_%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd5);
    tick();
    rsp_ready = 1'b0;
    check("t6_idle_after", 32'(cr3), 32'd1);
`ifdef ALU_CMD_DRIVER_OP_COUNT_EN
    check("t6_op_count", 32'(opc3), 32'd4);
    check("t6_op_count_dut1", 32'(opc1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
